ram_responder: RTL and testbench
================================

# ram_responder

Memory-side responder for the CPU's RAM request protocol: accepts read/write requests from the datapath/cache side and answers with `ramstate_t` status (FREE/BUSY/ACCESS/ERROR) after a configurable latency. It backs a word-addressed storage array and is the other end of the same interface the processor drives (`ramREN`/`ramWEN`/`ramaddr`/`ramstore` in, `ramload`/`ramstate` out). It is used as the system memory model in CPU-level simulation.

## Interface
- `LAT`, 2: access latency in cycles, range 1..15.
- `DEPTH_W`, 10: log2 of array depth in words (default 1024 words, 4 KB).
- `CLK`  in  1  system clock, all state on rising edge.
- `nRST`  in  1  asynchronous, active-low reset.
- `ramREN`  in  1  read request.
- `ramWEN`  in  1  write request.
- `ramaddr`  in  `word_t`  byte address.
- `ramstore`  in  `word_t`  write data.
- `ramload`  out  `word_t`  read data, valid only in the ACCESS cycle of a read.
- `ramstate`  out  `ramstate_t`  response status.
- `dbg_addr`  in  `DEPTH_W`  testbench word index for memory dump.
- `dbg_data`  out  `word_t`  combinational contents at `dbg_addr`.

## Operation
- Request is "valid" when exactly one of `ramREN`/`ramWEN` is high, `ramaddr[1:0]==0`, and `ramaddr[31:DEPTH_W+2]==0`.
- Internal state: latched request (`lv` valid bit, op, word index `ramaddr[DEPTH_W+1:2]`), 4-bit counter `cnt`.
- A request "matches" when `lv` is set and its op and index equal the latched values.
- `ramstate` is combinational, evaluated in priority order:
  1. ERROR: both REN and WEN high, or misaligned, or out of range.
  2. FREE: neither REN nor WEN high.
  3. ACCESS: the request matches and `cnt==LAT`.
  4. BUSY: otherwise.
- Edge update:
  - ERROR or FREE: `lv<=0`, `cnt<=0`.
  - BUSY with a non-matching request: latch the request, `lv<=1`, `cnt<=1`.
  - BUSY with a matching request: `cnt<=cnt+1`.
  - ACCESS: if write, `mem[idx]<=ramstore`; then `lv<=0`, `cnt<=0`.
- A request held unchanged after ACCESS is treated as a new transaction and goes BUSY again.
- Changing op or address during BUSY aborts the old transaction and restarts the count. The old write is never committed.
- `ramstore` is sampled only at the ACCESS edge. Changes during BUSY do not restart the count.
- `ramload`:
  - `mem[idx]` during ACCESS of a read.
  - 0 in every other cycle, including ACCESS of a write.
- ERROR never modifies memory.

## Timing
- A new valid request first seen in cycle t: BUSY in cycles t..t+LAT-1, ACCESS in cycle t+LAT.
- Total latency is LAT+1 cycles including the issue cycle.
- Write data is visible to a read from the following cycle onward.
- Back-to-back requests: a new request issued in cycle t+LAT+1 starts its own BUSY sequence. Peak throughput is one access per LAT+1 cycles.
- Reset (asynchronous assert, any cycle):
  - `lv=0`, `cnt=0`, all memory words 0.
  - Outputs follow the combinational rules: `ramstate=FREE` if no request, else BUSY/ERROR; `ramload=0`.
  - A write in flight at reset is dropped.
- Release of `nRST` is synchronous to `CLK`. The first edge after release behaves as a normal update.
- Counter never exceeds LAT.

## Structure
- Uses `word_t`, `ramstate_t`, and `WBYTES` from `cpu_types_pkg`. No new package typedefs.
- The latched-request struct (valid, op, index) is local to the module.
- One sub-module: `ram_array`, parameterized by `DEPTH_W`, with:
  - one synchronous write port with async-reset clear;
  - two combinational read ports (access and debug).
- FSM, counter, and error decode live in `ram_responder`.

## Test plan
- LAT=2, write 0xDEADBEEF to 0x0000_0010: `ramstate` BUSY, BUSY, then ACCESS. Then read 0x10: BUSY, BUSY, ACCESS with `ramload=0xDEADBEEF`; `dbg_addr=4` also gives 0xDEADBEEF.
- Read 0x14 with `ramaddr` changed to 0x18 after 1 BUSY cycle: counting restarts, ACCESS comes 2 cycles after the change, `ramload` = contents of word 6.
- Write 0x0000_0012 (misaligned), `ramaddr=0x0001_0000` with DEPTH_W=10 (out of range), and REN&WEN both high: each gives ERROR immediately, and `dbg_data` is unchanged.
- Write 0x1234 to 0x20, then assert `nRST` low during the second BUSY cycle: `ramstate=BUSY`, `ramload=0`. After release, word 8 reads 0.
- Hold a read of 0x10 for 7 cycles with LAT=2: sequence is B,B,A,B,B,A,B.
- LAT=1, alternating write 0x5/read to 0x40: B,A,B,A with read `ramload=0x5`.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: machine word and RAM response status.
package cpu_types_pkg;
    localparam int WORD_W = 32;
    localparam int WBYTES = WORD_W / 8;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;
endpackage

// File: rtl/ram_responder_pkg.sv
// Constants shared by the RAM responder and its storage array.
package ram_responder_pkg;
    import cpu_types_pkg::*;

    localparam int CNT_W      = 4;
    localparam int BYTE_OFS_W = $clog2(WBYTES);
endpackage

// File: rtl/ram_responder_if.sv
// RAM request bus between the processor (master) and the memory (slave).
interface ram_responder_if;
    import cpu_types_pkg::*;

    // Level protocol: the master holds ramREN/ramWEN, ramaddr (and ramstore
    // for writes) stable until ramstate reports ACCESS, which completes the
    // transfer on that rising edge; changing the request earlier aborts it.
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    modport master (
        output ramREN, ramWEN, ramaddr, ramstore,
        input  ramload, ramstate
    );

    modport slave (
        input  ramREN, ramWEN, ramaddr, ramstore,
        output ramload, ramstate
    );
endinterface

// File: rtl/ram_array.sv
// Word-addressed storage: one synchronous write port cleared by reset,
// plus combinational access and debug read ports.
module ram_array
    import cpu_types_pkg::*;
#(
    parameter int DEPTH_W = 10
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               we_i,
    input  logic [DEPTH_W-1:0] waddr_i,
    input  word_t              wdata_i,
    input  logic [DEPTH_W-1:0] raddr_i,
    output word_t              rdata_o,
    input  logic [DEPTH_W-1:0] dbg_addr_i,
    output word_t              dbg_data_o
);
    localparam int DEPTH = 2 ** DEPTH_W;

    word_t mem_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o    = mem_q[raddr_i];
    assign dbg_data_o = mem_q[dbg_addr_i];
endmodule

// File: rtl/ram_responder.sv
// Memory-side responder: answers RAM requests with BUSY for LAT cycles,
// then ACCESS, backed by ram_array.
module ram_responder
    import cpu_types_pkg::*;
    import ram_responder_pkg::*;
#(
    parameter int LAT     = 2,
    parameter int DEPTH_W = 10
) (
    input  logic               CLK,
    input  logic               nRST,
    ram_responder_if.slave     bus,
    input  logic [DEPTH_W-1:0] dbg_addr,
    output word_t              dbg_data,
    output logic [CNT_W-1:0]   dbg_cnt,
    output logic               dbg_lv
);
    typedef struct packed {
        logic               valid;
        logic               wr;
        logic [DEPTH_W-1:0] idx;
    } lreq_t;

    lreq_t            req_q;
    logic [CNT_W-1:0] cnt_q;

    logic               req_any;
    logic               req_bad;
    logic               match;
    logic [DEPTH_W-1:0] idx;
    ramstate_t          state_c;
    logic               mem_we;
    word_t              mem_rdata;

    assign idx     = bus.ramaddr[DEPTH_W+BYTE_OFS_W-1:BYTE_OFS_W];
    assign req_any = bus.ramREN | bus.ramWEN;
    // Address checks only matter when something is actually requested.
    assign req_bad = (bus.ramREN & bus.ramWEN)
                   | (req_any & (bus.ramaddr[BYTE_OFS_W-1:0] != '0))
                   | (req_any & ((bus.ramaddr >> (DEPTH_W + BYTE_OFS_W)) != '0));
    assign match   = req_q.valid && (req_q.wr == bus.ramWEN) && (req_q.idx == idx);

    always_comb begin
        state_c = BUSY;
        if (req_bad) begin
            state_c = ERROR;
        end else if (!req_any) begin
            state_c = FREE;
        end else if (match && (cnt_q == CNT_W'(LAT))) begin
            state_c = ACCESS;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            req_q <= '0;
            cnt_q <= '0;
        end else begin
            unique case (state_c)
                BUSY: begin
                    if (match) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end else begin
                        req_q <= '{valid: 1'b1, wr: bus.ramWEN, idx: idx};
                        cnt_q <= CNT_W'(1);
                    end
                end
                default: begin
                    req_q <= '0;
                    cnt_q <= '0;
                end
            endcase
        end
    end

    // Write data is taken straight from the bus on the completing edge.
    assign mem_we = (state_c == ACCESS) && req_q.wr;

    ram_array #(
        .DEPTH_W (DEPTH_W)
    ) u_ram_array (
        .clk_i      (CLK),
        .rst_ni     (nRST),
        .we_i       (mem_we),
        .waddr_i    (req_q.idx),
        .wdata_i    (bus.ramstore),
        .raddr_i    (req_q.idx),
        .rdata_o    (mem_rdata),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data)
    );

    assign bus.ramstate = state_c;
    assign bus.ramload  = ((state_c == ACCESS) && !req_q.wr) ? mem_rdata : '0;
    assign dbg_cnt      = cnt_q;
    assign dbg_lv       = req_q.valid;
endmodule

// File: tb/tb_ram_responder.sv
// Self-checking bench for ram_responder: LAT=2 and LAT=1 instances.
module tb_ram_responder;
  import cpu_types_pkg::*;

  typedef struct packed {
    logic      ren;
    logic      wen;
    word_t     addr;
    word_t     data;
    ramstate_t es;
    word_t     el;
  } step_t;

  logic clk = 1'b0;
  logic nrst = 1'b1;
  always #5 clk = ~clk;

  ram_responder_if bus2();
  ram_responder_if bus1();

  logic [9:0] dbg_addr2, dbg_addr1;
  word_t      dbg_data2, dbg_data1;
  logic [3:0] dbg_cnt2, dbg_cnt1;
  logic       dbg_lv2, dbg_lv1;

  ram_responder #(.LAT(2), .DEPTH_W(10)) u_dut2 (
    .CLK(clk), .nRST(nrst), .bus(bus2),
    .dbg_addr(dbg_addr2), .dbg_data(dbg_data2), .dbg_cnt(dbg_cnt2), .dbg_lv(dbg_lv2)
  );

  ram_responder #(.LAT(1), .DEPTH_W(10)) u_dut1 (
    .CLK(clk), .nRST(nrst), .bus(bus1),
    .dbg_addr(dbg_addr1), .dbg_data(dbg_data1), .dbg_cnt(dbg_cnt1), .dbg_lv(dbg_lv1)
  );

  int checks = 0;
  int failures = 0;
  logic [33:0] exp_q[$];

  // ---------------- clock/reset helpers and drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus2.ramREN = 1'b0; bus2.ramWEN = 1'b0; bus2.ramaddr = '0; bus2.ramstore = '0;
    bus1.ramREN = 1'b0; bus1.ramWEN = 1'b0; bus1.ramaddr = '0; bus1.ramstore = '0;
  endtask

  task automatic drive2(input step_t s);
    bus2.ramREN = s.ren; bus2.ramWEN = s.wen; bus2.ramaddr = s.addr; bus2.ramstore = s.data;
    exp_q.push_back({s.es, s.el});
  endtask

  task automatic drive1(input step_t s);
    bus1.ramREN = s.ren; bus1.ramWEN = s.wen; bus1.ramaddr = s.addr; bus1.ramstore = s.data;
    exp_q.push_back({s.es, s.el});
  endtask

  function automatic step_t st(input logic ren, input logic wen, input word_t addr,
                               input word_t data, input ramstate_t es, input word_t el);
    st = '{ren: ren, wen: wen, addr: addr, data: data, es: es, el: el};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_all();
    dbg_addr2 = 10'd4;
    dbg_addr1 = 10'd4;
    #1 nrst = 1'b0;
    #2;
    checks++;
    if (bus2.ramstate !== FREE || bus2.ramload !== 32'h0) begin
      failures++;
      $display("FAIL reset_idle2: got st=%0d ld=%h exp st=0 ld=0", bus2.ramstate, bus2.ramload);
    end
    checks++;
    if (bus1.ramstate !== FREE || bus1.ramload !== 32'h0) begin
      failures++;
      $display("FAIL reset_idle1: got st=%0d ld=%h exp st=0 ld=0", bus1.ramstate, bus1.ramload);
    end
    checks++;
    if (dbg_data2 !== 32'h0 || dbg_cnt2 !== 4'd0 || dbg_lv2 !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got dbg=%h cnt=%0d lv=%0d exp 0 0 0", dbg_data2, dbg_cnt2, dbg_lv2);
    end
    bus2.ramREN = 1'b1; bus2.ramaddr = 32'h10;
    @(posedge clk);
    #1;
    checks++;
    if (bus2.ramstate !== BUSY || bus2.ramload !== 32'h0 || dbg_cnt2 !== 4'd0) begin
      failures++;
      $display("FAIL reset_req: got st=%0d ld=%h cnt=%0d exp st=1 ld=0 cnt=0",
               bus2.ramstate, bus2.ramload, dbg_cnt2);
    end
    idle_all();
    @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    step_t s[$];
    logic [33:0] exp_v, got_v;
    s.push_back(st(0, 1, 32'h10, 32'hDEADBEEF, BUSY, 32'h0));
    s.push_back(st(0, 1, 32'h10, 32'hDEADBEEF, BUSY, 32'h0));
    s.push_back(st(0, 1, 32'h10, 32'hDEADBEEF, ACCESS, 32'h0));
    s.push_back(st(1, 0, 32'h10, 32'h0, BUSY, 32'h0));
    s.push_back(st(1, 0, 32'h10, 32'h0, BUSY, 32'h0));
    s.push_back(st(1, 0, 32'h10, 32'h0, ACCESS, 32'hDEADBEEF));
    s.push_back(st(0, 0, 32'h0, 32'h0, FREE, 32'h0));
    foreach (s[i]) begin
      drive2(s[i]);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      got_v = {bus2.ramstate, bus2.ramload};
      checks++;
      if (got_v !== exp_v) begin
        failures++;
        $display("FAIL write_read step%0d: got st=%0d ld=%h exp st=%0d ld=%h",
                 i, got_v[33:32], got_v[31:0], exp_v[33:32], exp_v[31:0]);
      end
      tick();
    end
    dbg_addr2 = 10'd4;
    #1;
    checks++;
    if (dbg_data2 !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL dbg_word4: got %h exp deadbeef", dbg_data2);
    end
  endtask

  task automatic test_abort();
    step_t s[$];
    logic [33:0] exp_v, got_v;
    for (int k = 0; k < 3; k++)
      s.push_back(st(0, 1, 32'h14, 32'h11110005, (k == 2) ? ACCESS : BUSY, 32'h0));
    for (int k = 0; k < 3; k++)
      s.push_back(st(0, 1, 32'h18, 32'hA5A50006, (k == 2) ? ACCESS : BUSY, 32'h0));
    s.push_back(st(1, 0, 32'h14, 32'h0, BUSY, 32'h0));
    s.push_back(st(1, 0, 32'h18, 32'h0, BUSY, 32'h0));
    s.push_back(st(1, 0, 32'h18, 32'h0, BUSY, 32'h0));
    s.push_back(st(1, 0, 32'h18, 32'h0, ACCESS, 32'hA5A50006));
    // aborted write must leave word 7 untouched
    s.push_back(st(0, 1, 32'h1C, 32'hBAD0BAD0, BUSY, 32'h0));
    s.push_back(st(1, 0, 32'h1C, 32'h0, BUSY, 32'h0));
    s.push_back(st(1, 0, 32'h1C, 32'h0, BUSY, 32'h0));
    s.push_back(st(1, 0, 32'h1C, 32'h0, ACCESS, 32'h0));
    // store data changing mid-transaction does not restart; last value lands
    s.push_back(st(0, 1, 32'h24, 32'h1, BUSY, 32'h0));
    s.push_back(st(0, 1, 32'h24, 32'h2, BUSY, 32'h0));
    s.push_back(st(0, 1, 32'h24, 32'h3, ACCESS, 32'h0));
    s.push_back(st(1, 0, 32'h24, 32'h0, BUSY, 32'h0));
    s.push_back(st(1, 0, 32'h24, 32'h0, BUSY, 32'h0));
    s.push_back(st(1, 0, 32'h24, 32'h0, ACCESS, 32'h3));
    s.push_back(st(0, 0, 32'h0, 32'h0, FREE, 32'h0));
    foreach (s[i]) begin
      drive2(s[i]);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      got_v = {bus2.ramstate, bus2.ramload};
      checks++;
      if (got_v !== exp_v) begin
        failures++;
        $display("FAIL abort step%0d: got st=%0d ld=%h exp st=%0d ld=%h",
                 i, got_v[33:32], got_v[31:0], exp_v[33:32], exp_v[31:0]);
      end
      tick();
    end
  endtask

  task automatic test_error();
    step_t s[$];
    logic [33:0] exp_v, got_v;
    dbg_addr2 = 10'd4;
    s.push_back(st(0, 1, 32'h12, 32'h12345678, ERROR, 32'h0));
    s.push_back(st(1, 0, 32'h13, 32'h0, ERROR, 32'h0));
    s.push_back(st(0, 1, 32'h0001_0000, 32'h12345678, ERROR, 32'h0));
    s.push_back(st(1, 0, 32'h0001_0000, 32'h0, ERROR, 32'h0));
    s.push_back(st(1, 1, 32'h10, 32'h12345678, ERROR, 32'h0));
    s.push_back(st(0, 1, 32'h10, 32'h0, BUSY, 32'h0));
    s.push_back(st(1, 1, 32'h10, 32'h0, ERROR, 32'h0));
    s.push_back(st(0, 1, 32'h10, 32'h0, BUSY, 32'h0));
    s.push_back(st(0, 1, 32'h10, 32'h0, BUSY, 32'h0));
    s.push_back(st(0, 0, 32'h0, 32'h0, FREE, 32'h0));
    foreach (s[i]) begin
      drive2(s[i]);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      got_v = {bus2.ramstate, bus2.ramload};
      checks++;
      if (got_v !== exp_v) begin
        failures++;
        $display("FAIL error step%0d: got st=%0d ld=%h exp st=%0d ld=%h",
                 i, got_v[33:32], got_v[31:0], exp_v[33:32], exp_v[31:0]);
      end
      tick();
    end
    checks++;
    if (dbg_data2 !== 32'hDEADBEEF || dbg_cnt2 !== 4'd0) begin
      failures++;
      $display("FAIL error_mem: got dbg=%h cnt=%0d exp deadbeef 0", dbg_data2, dbg_cnt2);
    end
  endtask

  task automatic test_back_to_back();
    step_t s[$];
    logic [33:0] exp_v, got_v;
    for (int k = 0; k < 7; k++)
      s.push_back(st(1, 0, 32'h10, 32'h0, (k % 3 == 2) ? ACCESS : BUSY,
                     (k % 3 == 2) ? 32'hDEADBEEF : 32'h0));
    s.push_back(st(0, 0, 32'h0, 32'h0, FREE, 32'h0));
    foreach (s[i]) begin
      drive2(s[i]);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      got_v = {bus2.ramstate, bus2.ramload};
      checks++;
      if (got_v !== exp_v) begin
        failures++;
        $display("FAIL hold step%0d: got st=%0d ld=%h exp st=%0d ld=%h",
                 i, got_v[33:32], got_v[31:0], exp_v[33:32], exp_v[31:0]);
      end
      tick();
    end
  endtask

  task automatic test_reset_midflight();
    step_t s[$];
    logic [33:0] exp_v, got_v;
    drive2(st(0, 1, 32'h20, 32'h1234, BUSY, 32'h0));
    @(negedge clk);
    exp_v = exp_q.pop_front();
    got_v = {bus2.ramstate, bus2.ramload};
    checks++;
    if (got_v !== exp_v) begin
      failures++;
      $display("FAIL rst_mid busy1: got st=%0d ld=%h exp st=%0d ld=%h",
               got_v[33:32], got_v[31:0], exp_v[33:32], exp_v[31:0]);
    end
    tick();
    drive2(st(0, 1, 32'h20, 32'h1234, BUSY, 32'h0));
    #2 nrst = 1'b0;
    @(negedge clk);
    exp_v = exp_q.pop_front();
    got_v = {bus2.ramstate, bus2.ramload};
    checks++;
    if (got_v !== exp_v) begin
      failures++;
      $display("FAIL rst_mid busy2: got st=%0d ld=%h exp st=%0d ld=%h",
               got_v[33:32], got_v[31:0], exp_v[33:32], exp_v[31:0]);
    end
    checks++;
    if (dbg_cnt2 !== 4'd0 || dbg_lv2 !== 1'b0 || dbg_data2 !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid state: got cnt=%0d lv=%0d dbg=%h exp 0 0 0", dbg_cnt2, dbg_lv2, dbg_data2);
    end
    idle_all();
    @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    tick();
    dbg_addr2 = 10'd8;
    s.push_back(st(1, 0, 32'h20, 32'h0, BUSY, 32'h0));
    s.push_back(st(1, 0, 32'h20, 32'h0, BUSY, 32'h0));
    s.push_back(st(1, 0, 32'h20, 32'h0, ACCESS, 32'h0));
    s.push_back(st(0, 0, 32'h0, 32'h0, FREE, 32'h0));
    foreach (s[i]) begin
      drive2(s[i]);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      got_v = {bus2.ramstate, bus2.ramload};
      checks++;
      if (got_v !== exp_v) begin
        failures++;
        $display("FAIL rst_mid read step%0d: got st=%0d ld=%h exp st=%0d ld=%h",
                 i, got_v[33:32], got_v[31:0], exp_v[33:32], exp_v[31:0]);
      end
      tick();
    end
    checks++;
    if (dbg_data2 !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid word8: got %h exp 0", dbg_data2);
    end
  endtask

  task automatic test_lat1();
    step_t s[$];
    logic [33:0] exp_v, got_v;
    logic [9:0] idx;
    word_t addr, data;
    for (int n = 0; n < 5; n++) begin
      idx  = (n == 0) ? 10'h10 : 10'($urandom_range(0, 1023));
      data = (n == 0) ? 32'h5 : $urandom;
      addr = {20'h0, idx, 2'b00};
      s.push_back(st(0, 1, addr, data, BUSY, 32'h0));
      s.push_back(st(0, 1, addr, data, ACCESS, 32'h0));
      s.push_back(st(1, 0, addr, 32'h0, BUSY, 32'h0));
      s.push_back(st(1, 0, addr, 32'h0, ACCESS, data));
    end
    s.push_back(st(0, 0, 32'h0, 32'h0, FREE, 32'h0));
    foreach (s[i]) begin
      drive1(s[i]);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      got_v = {bus1.ramstate, bus1.ramload};
      checks++;
      if (got_v !== exp_v) begin
        failures++;
        $display("FAIL lat1 step%0d: got st=%0d ld=%h exp st=%0d ld=%h",
                 i, got_v[33:32], got_v[31:0], exp_v[33:32], exp_v[31:0]);
      end
      tick();
    end
    dbg_addr1 = idx;
    #1;
    checks++;
    if (dbg_data1 !== data) begin
      failures++;
      $display("FAIL lat1_dbg: got %h exp %h", dbg_data1, data);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_write_read();
    test_abort();
    test_error();
    test_back_to_back();
    test_reset_midflight();
    test_lat1();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries left exp 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
